// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: block geometry, round-constant arithmetic,
// pipeline-stage state encoding and byte-lane access.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam logic [7:0] AES_RCON_INIT = 8'h01;

    // Encoding doubles as the stage occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte 0 is the most significant lane of a block of nbytes lanes.
    function automatic logic [7:0] state_byte(input logic [8*32-1:0] blk,
                                              input int nbytes,
                                              input int k);
        return blk[8*(nbytes-k)-1 -: 8];
    endfunction

endpackage

// File: rtl/aes_pipe_stage_reg.sv
// Inter-round AES pipeline register with valid/ready handshake, two-entry skid
// storage, synchronous flush and optional round-constant advance at capture.
module aes_pipe_stage_reg
    import aes_pkg::*;
#(
    parameter int NBYTES     = 16,
    parameter int TAG_W      = 4,
    parameter int RCON_ADV   = 1,
    parameter int LAST_ROUND = 10
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_state,
    input  logic [7:0]          in_rcon,
    input  logic [TAG_W-1:0]    in_round,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_state,
    output logic [7:0]          out_rcon,
    output logic [TAG_W-1:0]    out_round,
    output logic                out_last,
    output logic [1:0]          occupancy
);

    localparam int W = 8 * NBYTES;

    stage_state_e     state_q, state_d;
    logic [W-1:0]     main_state_q, skid_state_q;
    logic [7:0]       main_rcon_q, skid_rcon_q;
    logic [TAG_W-1:0] main_round_q, skid_round_q;

    logic       in_fire, out_fire;
    logic       load_main_in, load_main_skid, load_skid;
    logic [7:0] rcon_cap;

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = state_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Rcon is advanced on the way in, so skid already holds the final value.
    assign rcon_cap = (RCON_ADV != 0) ? xtime(in_rcon) : in_rcon;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_d      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = ST_TWO;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_d        = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush empties the stage but leaves the data registers untouched.
        if (flush) begin
            state_d        = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            main_state_q <= '0;
            main_rcon_q  <= '0;
            main_round_q <= '0;
            skid_state_q <= '0;
            skid_rcon_q  <= '0;
            skid_round_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_state_q <= in_state;
                main_rcon_q  <= rcon_cap;
                main_round_q <= in_round;
            end else if (load_main_skid) begin
                main_state_q <= skid_state_q;
                main_rcon_q  <= skid_rcon_q;
                main_round_q <= skid_round_q;
            end
            if (load_skid) begin
                skid_state_q <= in_state;
                skid_rcon_q  <= rcon_cap;
                skid_round_q <= in_round;
            end
        end
    end

    assign out_state = main_state_q;
    assign out_rcon  = main_rcon_q;
    assign out_round = main_round_q;
    assign out_last  = out_valid && (main_round_q == TAG_W'(LAST_ROUND));

endmodule

// File: tb/tb_aes_pipe_stage_reg.sv
// Directed and random checks of aes_pipe_stage_reg at 16, 4 and 32 byte lanes,
// with a queue scoreboard modelling the handshake.
module tb_aes_pipe_stage_reg;
    import aes_pkg::*;

    typedef struct {
        logic [255:0] st;
        logic [7:0]   rc;
        logic [3:0]   rd;
    } blk_t;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         inValid = 1'b0;
    logic         outReady = 1'b0;
    logic [255:0] inState = '0;
    logic [7:0]   inRcon = '0;
    logic [3:0]   inRound = '0;

    always #5 clock = ~clock;

    logic         inReady16, outValid16, outLast16;
    logic [127:0] outState16;
    logic [7:0]   outRcon16;
    logic [3:0]   outRound16;
    logic [1:0]   occ16;

    logic         inReady4, outValid4, outLast4;
    logic [31:0]  outState4;
    logic [7:0]   outRcon4;
    logic [3:0]   outRound4;
    logic [1:0]   occ4;

    logic         inReady32, outValid32, outLast32;
    logic [255:0] outState32;
    logic [7:0]   outRcon32;
    logic [3:0]   outRound32;
    logic [1:0]   occ32;

    aes_pipe_stage_reg #(.NBYTES(16), .TAG_W(4), .RCON_ADV(1), .LAST_ROUND(10)) dut16 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(inValid), .in_ready(inReady16), .in_state(inState[127:0]),
        .in_rcon(inRcon), .in_round(inRound),
        .out_valid(outValid16), .out_ready(outReady), .out_state(outState16),
        .out_rcon(outRcon16), .out_round(outRound16), .out_last(outLast16),
        .occupancy(occ16)
    );

    aes_pipe_stage_reg #(.NBYTES(4), .TAG_W(4), .RCON_ADV(0), .LAST_ROUND(10)) dut4 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(inValid), .in_ready(inReady4), .in_state(inState[31:0]),
        .in_rcon(inRcon), .in_round(inRound),
        .out_valid(outValid4), .out_ready(outReady), .out_state(outState4),
        .out_rcon(outRcon4), .out_round(outRound4), .out_last(outLast4),
        .occupancy(occ4)
    );

    aes_pipe_stage_reg #(.NBYTES(32), .TAG_W(4), .RCON_ADV(1), .LAST_ROUND(10)) dut32 (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(inValid), .in_ready(inReady32), .in_state(inState),
        .in_rcon(inRcon), .in_round(inRound),
        .out_valid(outValid32), .out_ready(outReady), .out_state(outState32),
        .out_rcon(outRcon32), .out_round(outRound32), .out_last(outLast32),
        .occupancy(occ32)
    );

    int           sel = 0;
    int           checks = 0;
    int           fails = 0;
    blk_t         sbQ[$];

    logic         obsReady, obsValid, obsLast;
    logic [255:0] obsState;
    logic [7:0]   obsRcon;
    logic [3:0]   obsRound;
    logic [1:0]   obsOcc;

    // Route the instance under test onto one common set of observation signals.
    always_comb begin
        obsReady = inReady16;  obsValid = outValid16; obsLast = outLast16;
        obsState = {128'b0, outState16}; obsRcon = outRcon16;
        obsRound = outRound16; obsOcc = occ16;
        if (sel == 1) begin
            obsReady = inReady4;  obsValid = outValid4; obsLast = outLast4;
            obsState = {224'b0, outState4}; obsRcon = outRcon4;
            obsRound = outRound4; obsOcc = occ4;
        end else if (sel == 2) begin
            obsReady = inReady32; obsValid = outValid32; obsLast = outLast32;
            obsState = outState32; obsRcon = outRcon32;
            obsRound = outRound32; obsOcc = occ32;
        end
    end

    function automatic logic [7:0] refXtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [255:0] laneMask(input int n);
        logic [255:0] m = '0;
        for (int i = 0; i < 8 * n; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int laneCount(input int s);
        return (s == 1) ? 4 : ((s == 2) ? 32 : 16);
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check handshake state against the scoreboard, retire/accept, advance.
    task automatic applyStimulus();
        blk_t e;
        @(negedge clock);
        checkOutput("occupancy", 256'(obsOcc), 256'(sbQ.size()));
        checkOutput("out_valid", 256'(obsValid), 256'(sbQ.size() != 0));
        checkOutput("in_ready", 256'(obsReady), 256'(sbQ.size() < 2));
        if (obsValid && outReady && sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkOutput("sb_state", obsState, e.st);
            checkOutput("sb_rcon", 256'(obsRcon), 256'(e.rc));
            checkOutput("sb_round", 256'(obsRound), 256'(e.rd));
        end
        if (!reset_n || flush) begin
            sbQ.delete();
        end else if (inValid && obsReady) begin
            e.st = inState & laneMask(laneCount(sel));
            e.rc = (sel == 1) ? inRcon : refXtime(inRcon);
            e.rd = inRound;
            sbQ.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic resetAll(input int newSel);
        inValid  = 1'b0;
        flush    = 1'b0;
        reset_n  = 1'b0;
        applyStimulus();
        applyStimulus();
        sel      = newSel;
        reset_n  = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_out_valid", 256'(obsValid), 256'd0);
        checkOutput("rst_in_ready", 256'(obsReady), 256'd1);
        checkOutput("rst_out_state", obsState, 256'd0);
        checkOutput("rst_out_rcon", 256'(obsRcon), 256'd0);
        checkOutput("rst_out_round", 256'(obsRound), 256'd0);
        checkOutput("rst_out_last", 256'(obsLast), 256'd0);
        checkOutput("rst_occupancy", 256'(obsOcc), 256'd0);
        reset_n = 1'b1;

        // Single block, one-cycle latency.
        inState  = 256'h000102030405060708090a0b0c0d0e0f;
        inRcon   = 8'h01;
        inRound  = 4'd1;
        outReady = 1'b1;
        inValid  = 1'b1;
        applyStimulus();
        inValid  = 1'b0;
        checkOutput("single_state", obsState, 256'h000102030405060708090a0b0c0d0e0f);
        checkOutput("single_lane15", 256'(state_byte(obsState, 16, 15)), 256'h0f);
        checkOutput("single_rcon", 256'(obsRcon), 256'h02);
        checkOutput("single_valid", 256'(obsValid), 256'd1);
        checkOutput("single_occ", 256'(obsOcc), 256'd1);
        applyStimulus();

        // Rcon wrap with advance enabled, then pass-through on the 4-lane instance.
        for (int pass = 0; pass < 2; pass++) begin
            logic [7:0] rin [3];
            logic [7:0] rexp [3];
            rin = '{8'h80, 8'h1b, 8'h36};
            if (pass == 0) rexp = '{8'h1b, 8'h36, 8'h6c};
            else           rexp = '{8'h80, 8'h1b, 8'h36};
            outReady = 1'b1;
            inValid  = 1'b1;
            for (int i = 0; i < 3; i++) begin
                inState = 256'(32'hcafe0000 + i);
                inRcon  = rin[i];
                inRound = 4'd2;
                applyStimulus();
                checkOutput("rcon_wrap", 256'(obsRcon), 256'(rexp[i]));
            end
            inValid = 1'b0;
            applyStimulus();
            resetAll(pass == 0 ? 1 : 0);
        end

        // Backpressure fills main and skid; third block waits upstream.
        outReady = 1'b0;
        inValid  = 1'b1;
        inRound  = 4'd3;
        inRcon   = 8'h04;
        inState  = 256'h101112131415161718191a1b1c1d1e1f;
        applyStimulus();
        inState  = 256'h202122232425262728292a2b2c2d2e2f;
        applyStimulus();
        checkOutput("bp_occ_two", 256'(obsOcc), 256'd2);
        checkOutput("bp_in_ready", 256'(obsReady), 256'd0);
        inState  = 256'h303132333435363738393a3b3c3d3e3f;
        applyStimulus();
        checkOutput("bp_held_state", obsState, 256'h101112131415161718191a1b1c1d1e1f);
        outReady = 1'b1;
        applyStimulus();
        checkOutput("bp_drain_2", obsState, 256'h202122232425262728292a2b2c2d2e2f);
        applyStimulus();
        inValid  = 1'b0;
        checkOutput("bp_drain_3", obsState, 256'h303132333435363738393a3b3c3d3e3f);
        checkOutput("bp_no_gap", 256'(obsValid), 256'd1);
        applyStimulus();
        checkOutput("bp_empty", 256'(obsOcc), 256'd0);

        // Last-round flag follows the valid block carrying tag 10 only.
        outReady = 1'b0;
        inValid  = 1'b1;
        inRound  = 4'd10;
        applyStimulus();
        inValid  = 1'b0;
        checkOutput("last_high", 256'(obsLast), 256'd1);
        outReady = 1'b1;
        applyStimulus();
        checkOutput("last_gone", 256'(obsLast), 256'd0);
        outReady = 1'b0;
        inValid  = 1'b1;
        inRound  = 4'd9;
        applyStimulus();
        inValid  = 1'b0;
        checkOutput("last_round9", 256'(obsLast), 256'd0);
        checkOutput("last_round9_valid", 256'(obsValid), 256'd1);
        outReady = 1'b1;
        applyStimulus();

        // Flush from TWO discards the incoming block but keeps output data.
        outReady = 1'b0;
        inValid  = 1'b1;
        inRound  = 4'd5;
        inState  = 256'haaaa;
        applyStimulus();
        inState  = 256'hbbbb;
        applyStimulus();
        inState  = 256'hcccc;
        flush    = 1'b1;
        applyStimulus();
        flush    = 1'b0;
        inValid  = 1'b0;
        checkOutput("flush_occ", 256'(obsOcc), 256'd0);
        checkOutput("flush_valid", 256'(obsValid), 256'd0);
        checkOutput("flush_ready", 256'(obsReady), 256'd1);
        checkOutput("flush_data_hold", obsState, 256'haaaa);
        outReady = 1'b1;
        applyStimulus();
        applyStimulus();

        // Reset dominates a simultaneous flush and clears the data.
        inValid  = 1'b1;
        inRcon   = 8'h40;
        inState  = 256'h1234;
        applyStimulus();
        inValid  = 1'b0;
        reset_n  = 1'b0;
        flush    = 1'b1;
        applyStimulus();
        checkOutput("rstflush_state", obsState, 256'd0);
        checkOutput("rstflush_rcon", 256'(obsRcon), 256'd0);
        checkOutput("rstflush_ready", 256'(obsReady), 256'd1);
        reset_n  = 1'b1;
        flush    = 1'b0;

        // Random handshake stress on the narrow and wide instances.
        for (int s = 1; s <= 2; s++) begin
            resetAll(s);
            for (int c = 0; c < 5000; c++) begin
                inValid  = 1'($urandom_range(0, 1));
                outReady = 1'($urandom_range(0, 1));
                for (int w = 0; w < 8; w++) inState[32*w +: 32] = $urandom;
                inRcon   = 8'($urandom);
                inRound  = 4'($urandom);
                applyStimulus();
            end
            inValid  = 1'b0;
            outReady = 1'b1;
            for (int i = 0; i < 8 && sbQ.size() != 0; i++) applyStimulus();
            checkOutput("stress_drained", 256'(obsOcc), 256'd0);
            checkOutput("stress_sb_empty", 256'(sbQ.size()), 256'd0);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
